// File: rtl/io_timer_intr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_timer_intr : IO-bus scratch RAM plus a down-counter timer with interrupt.
// Optional macro IO_SWINT_EN adds a software interrupt trigger (STATUS[2]).
// Revision: 1.0
// ---------------------------------------------------------------------------
module io_timer_intr #(
  parameter int RAM_WORDS = 64
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] Addr,
  input  logic [31:0] D_in,
  output logic [31:0] D_out,
  output logic        intr,
  input  logic        int_ack
);

  localparam int         c_aw        = $clog2(RAM_WORDS);
  localparam logic [9:0] c_ram_words = 10'(RAM_WORDS);
  localparam logic [9:0] c_ctrl_idx  = 10'h3FC;
  localparam logic [9:0] c_per_idx   = 10'h3FD;
  localparam logic [9:0] c_cnt_idx   = 10'h3FE;
  localparam logic [9:0] c_stat_idx  = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKD = 2'd2
  } state_e;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    ram_d [RAM_WORDS];
  logic           en_q, en_d;
  logic           reload_q, reload_d;
  logic [31:0]    period_q, period_d;
  logic [31:0]    count_q, count_d;
  logic           pend_q, pend_d;
  logic           ovr_q, ovr_d;
  state_e         state_q, state_d;

  logic [9:0]     word_idx;
  logic [c_aw-1:0] ram_idx;
  logic           ram_hit;
  logic           we;
  logic           ctrl_wr, per_wr, stat_wr;
  logic           en_rise;
  logic           expire;
  logic           swi_set;
  logic           pend_set;
  logic           pend_clr;
  logic [31:0]    rd_data;
  logic           unused_addr;

  assign word_idx    = Addr[11:2];
  assign ram_idx     = word_idx[c_aw-1:0];
  assign ram_hit     = (word_idx < c_ram_words);
  assign unused_addr = ^{Addr[31:12], Addr[1:0]};

  assign we      = io_cs & io_wr;
  assign ctrl_wr = we & (word_idx == c_ctrl_idx);
  assign per_wr  = we & (word_idx == c_per_idx);
  assign stat_wr = we & (word_idx == c_stat_idx);
  assign en_rise = ctrl_wr & D_in[0] & ~en_q;
  assign expire  = en_q & (count_q == 32'd1);

`ifdef IO_SWINT_EN
  assign swi_set = stat_wr & D_in[2];
`else
  assign swi_set = 1'b0;
`endif

  assign pend_set = expire | swi_set;
  assign pend_clr = (state_q == REQ) & int_ack;

  always_comb begin
    ram_d = ram_q;
    if (we && ram_hit) ram_d[ram_idx] = D_in;
  end

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    period_d = period_q;
    count_d  = count_q;
    if (ctrl_wr) begin
      en_d     = D_in[0];
      reload_d = D_in[1];
    end
    if (per_wr) period_d = D_in;

    // A PERIOD write overrides any decrement or reload in the same cycle.
    if (per_wr) begin
      count_d = D_in;
    end else if (en_rise) begin
      count_d = period_q;
    end else if (en_q && (count_q > 32'd1)) begin
      count_d = count_q - 32'd1;
    end else if (expire) begin
      count_d = reload_q ? period_q : 32'd0;
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (pend_set) begin
      pend_d = 1'b1;
    end else if (pend_clr) begin
      pend_d = 1'b0;
    end
    // A new event on an unacknowledged one is an overrun; set beats clear.
    if (pend_set && pend_q) begin
      ovr_d = 1'b1;
    end else if (stat_wr && D_in[1]) begin
      ovr_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_q)   state_d = REQ;
      REQ:     if (int_ack)  state_d = ACKD;
      ACKD:    if (!int_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      ram_q    <= ram_d;
      en_q     <= en_d;
      reload_q <= reload_d;
      period_q <= period_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (ram_hit) begin
      rd_data = ram_q[ram_idx];
    end else begin
      case (word_idx)
        c_ctrl_idx: rd_data = {30'd0, reload_q, en_q};
        c_per_idx:  rd_data = period_q;
        c_cnt_idx:  rd_data = count_q;
        c_stat_idx: rd_data = {30'd0, ovr_q, pend_q};
        default:    rd_data = '0;
      endcase
    end
  end

  assign D_out = (io_cs & io_rd) ? rd_data : 32'hz;
  assign intr  = (state_q == REQ);

endmodule
`default_nettype wire
